// File: rtl/sprite_line_buffer_pkg.sv
// Shared video definitions for the sprite line buffer: default widths,
// hcount encoding and the pixel transparency test.
`timescale 1ns/1ps
package sprite_line_buffer_pkg;

    localparam int LB_AW            = 8;  // X address width, 256 pixels per line
    localparam int LB_DW            = 6;  // palette bank plus colour
    localparam int LB_TW            = 3;  // colour LSBs that encode transparency
    localparam int LB_HC_W          = 9;
    localparam int LB_HC_ACTIVE_BIT = 8;  // hcount[8] = active region

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lb_state_e;

    // A pixel is transparent when its low tw bits are all zero.
    function automatic logic is_transparent(input logic [31:0] data, input int tw);
        logic [31:0] mask;
        mask = (32'd1 << tw) - 32'd1;
        return (data & mask) == '0;
    endfunction

endpackage

// File: rtl/sprite_line_buffer_bank_ram.sv
// One line-buffer bank: a read-first clear port (registered read, writes 0)
// and an independent write port.
`timescale 1ns/1ps
module lb_bank_ram
    import sprite_line_buffer_pkg::*;
#(
    parameter int AW = LB_AW,
    parameter int DW = LB_DW
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_a_addr,
    input  logic          i_a_clr,
    output logic [DW-1:0] o_a_rdata,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata
);

    logic [DW-1:0] r_mem [2**AW];

    // NOTE: the array has no reset; the CLEAR state zeroes it explicitly so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        o_a_rdata <= r_mem[i_a_addr];
        if (i_a_clr) r_mem[i_a_addr] <= '0;
        if (i_b_we)  r_mem[i_b_addr] <= i_b_wdata;
    end

endmodule

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: the sprite engine fills bank ~bank while the
// display reads-and-clears bank `bank`; banks swap on the rising edge of hbl.
`timescale 1ns/1ps
module sprite_line_buffer
    import sprite_line_buffer_pkg::*;
#(
    parameter int AW = LB_AW,
    parameter int DW = LB_DW,
    parameter int TW = LB_TW
) (
    input  logic          clkm_6MHZ,
    input  logic          RESET,
    input  logic [8:0]    hcount,
    input  logic          hbl,
    input  logic          wr_valid,
    input  logic [AW-1:0] wr_x,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          bank,
    output logic          line_swap,
    output logic [DW-1:0] pix_out
);

    lb_state_e     r_state, w_state_next;
    logic          w_clearing, w_run;
    logic [AW-1:0] r_clr_cnt;
    logic          r_prev_hbl, r_bank, r_line_swap, w_hbl_rise;
    logic          r_s1_valid, r_s1_tag, r_s2_valid, r_s2_tag, r_s3_valid, r_s3_tag;
    logic [AW-1:0] r_s1_x, r_s2_x, r_s3_x;
    logic [DW-1:0] r_s1_data, r_s2_data;
    logic          w_s1_write, w_s1_old_opaque, w_s2_hit, w_s3_hit;
    logic [DW-1:0] w_s1_old, w_rd0, w_rd1;
    logic [AW-1:0] w_a_addr0, w_a_addr1;
    logic          w_a_clr0, w_a_clr1;
    logic          r_disp_valid, r_disp_bank;
    logic          w_unused_active;

    assign w_unused_active = hcount[LB_HC_ACTIVE_BIT];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clkm_6MHZ or posedge RESET) begin
        if (RESET) r_state <= ST_CLEAR;
        else       r_state <= w_state_next;
    end

    // NOTE: default assignment first, so no path through the block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == '1) w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_clearing = 1'b0;
        w_run      = 1'b0;
        case (r_state)
            ST_CLEAR: w_clearing = 1'b1;
            ST_RUN:   w_run      = 1'b1;
            default:  w_clearing = 1'b1;
        endcase
    end

    assign wr_ready = w_run;

    always_ff @(posedge clkm_6MHZ or posedge RESET) begin
        if (RESET)           r_clr_cnt <= '0;
        else if (w_clearing) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    assign w_hbl_rise = w_run & hbl & ~r_prev_hbl;

    always_ff @(posedge clkm_6MHZ or posedge RESET) begin
        if (RESET) begin
            r_prev_hbl  <= 1'b1;
            r_bank      <= 1'b0;
            r_line_swap <= 1'b0;
        end else begin
            r_prev_hbl  <= hbl;
            r_bank      <= r_bank ^ w_hbl_rise;
            r_line_swap <= w_hbl_rise;
        end
    end

    // Stage 1 sees the RAM read-first value; the pending write (s2) and the one
    // just committed (s3) are not in it yet, so a tag/X hit means "already opaque".
    assign w_s1_old        = r_s1_tag ? w_rd1 : w_rd0;
    assign w_s2_hit        = r_s2_valid & (r_s2_x == r_s1_x) & (r_s2_tag == r_s1_tag);
    assign w_s3_hit        = r_s3_valid & (r_s3_x == r_s1_x) & (r_s3_tag == r_s1_tag);
    assign w_s1_old_opaque = ~is_transparent(32'(w_s1_old), TW) | w_s2_hit | w_s3_hit;
    assign w_s1_write      = r_s1_valid & ~is_transparent(32'(r_s1_data), TW) & ~w_s1_old_opaque;

    always_ff @(posedge clkm_6MHZ or posedge RESET) begin
        if (RESET) begin
            r_s1_valid <= 1'b0;
            r_s1_tag   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_data  <= '0;
            r_s2_valid <= 1'b0;
            r_s2_tag   <= 1'b0;
            r_s2_x     <= '0;
            r_s2_data  <= '0;
            r_s3_valid <= 1'b0;
            r_s3_tag   <= 1'b0;
            r_s3_x     <= '0;
        end else begin
            r_s1_valid <= wr_valid & wr_ready;
            r_s1_tag   <= ~r_bank;
            r_s1_x     <= wr_x;
            r_s1_data  <= wr_data;
            r_s2_valid <= w_s1_write;
            r_s2_tag   <= r_s1_tag;
            r_s2_x     <= r_s1_x;
            r_s2_data  <= r_s1_data;
            r_s3_valid <= r_s2_valid;
            r_s3_tag   <= r_s2_tag;
            r_s3_x     <= r_s2_x;
        end
    end

    // Port A of the display bank reads-and-clears hcount; the write bank's port A
    // serves the stage-1 lookup. CLEAR drives both banks.
    assign w_a_addr0 = w_clearing ? r_clr_cnt : (r_bank ? wr_x : hcount[AW-1:0]);
    assign w_a_addr1 = w_clearing ? r_clr_cnt : (r_bank ? hcount[AW-1:0] : wr_x);
    assign w_a_clr0  = w_clearing | (w_run & ~r_bank & ~hbl);
    assign w_a_clr1  = w_clearing | (w_run &  r_bank & ~hbl);

    lb_bank_ram #(.AW(AW), .DW(DW)) u_bank0 (
        .i_clk     (clkm_6MHZ),
        .i_a_addr  (w_a_addr0),
        .i_a_clr   (w_a_clr0),
        .o_a_rdata (w_rd0),
        .i_b_we    (r_s2_valid & ~r_s2_tag),
        .i_b_addr  (r_s2_x),
        .i_b_wdata (r_s2_data)
    );

    lb_bank_ram #(.AW(AW), .DW(DW)) u_bank1 (
        .i_clk     (clkm_6MHZ),
        .i_a_addr  (w_a_addr1),
        .i_a_clr   (w_a_clr1),
        .o_a_rdata (w_rd1),
        .i_b_we    (r_s2_valid & r_s2_tag),
        .i_b_addr  (r_s2_x),
        .i_b_wdata (r_s2_data)
    );

    always_ff @(posedge clkm_6MHZ or posedge RESET) begin
        if (RESET) begin
            r_disp_valid <= 1'b0;
            r_disp_bank  <= 1'b0;
        end else begin
            r_disp_valid <= w_run & ~hbl;
            r_disp_bank  <= r_bank;
        end
    end

    assign pix_out   = r_disp_valid ? (r_disp_bank ? w_rd1 : w_rd0) : '0;
    assign bank      = r_bank;
    assign line_swap = r_line_swap;

endmodule

// File: doc/sprite_line_buffer.md
Name: sprite_line_buffer

Overview:
- Double-buffered (ping-pong) sprite line buffer, one stage downstream of the sync bus.
- The sprite engine renders the next scanline into the write bank while the display side reads the current line in pixel order, driven by the horizontal count and H.BL.
- Each display read clears its entry, so the bank is empty when it becomes the write bank again.
- Priority rule: the first opaque pixel written to an X position wins; later writes to that X are dropped.

Parameters:
- AW, 8, X address width (256 pixels per line).
- DW, 6, pixel data width (palette bank plus colour).
- TW, 3, number of pixel LSBs that select transparency; a pixel is transparent when data[TW-1:0]==0.

Ports:
- clkm_6MHZ  in  1  pixel clock; the only clock in the block.
- RESET  in  1  asynchronous, active-high reset.
- hcount  in  9  horizontal pixel counter from the sync bus, bit 8 = active region.
- hbl  in  1  horizontal blank, high = blank.
- wr_valid  in  1  sprite engine pixel write request.
- wr_x  in  AW  write X position.
- wr_data  in  DW  write pixel.
- wr_ready  out  1  write accepted this cycle when wr_valid & wr_ready.
- bank  out  1  current display bank index; the write bank is ~bank.
- line_swap  out  1  one-cycle pulse on a bank swap.
- pix_out  out  DW  display pixel, 0 during blank.

Behaviour:
- Storage: two banks of 2^AW x DW. Inference is RAM-style. The display port is read-first (it returns old data while writing 0 in the same cycle).
- Reset (asynchronous): FSM enters CLEAR.
  - bank=0, pix_out=0, line_swap=0, wr_ready=0, clear counter=0.
  - The write pipeline is flushed; no pending write survives reset.
- FSM CLEAR:
  - Writes 0 to address cnt in both banks each cycle.
  - After cnt==2^AW-1, goes to RUN on the next cycle (exactly 256 cycles at default).
  - hbl and hcount are ignored; pix_out is held at 0.
- FSM RUN: wr_ready=1 permanently. There is no back-pressure; the sprite engine may write every cycle.
- Write pipeline (write bank = ~bank, latched at stage 1):
  - Stage 1: register X, data, bank tag and valid; read the old entry.
  - Stage 2: write if the new pixel is opaque AND the old entry is transparent.
  - Transparent new pixels never write.
  - Hazard: back-to-back writes to the same X and bank tag forward the stage-2 result into the stage-1 compare, so first-opaque-wins still holds.
  - Latency: the buffer update is visible 2 cycles after acceptance.
- Display read:
  - When hbl=0, read address = hcount[AW-1:0] in bank `bank`; the entry is cleared to 0 in the same cycle.
  - pix_out is registered with 1-cycle latency; pix_out=0 in the cycle after any hbl=1 cycle.
- Swap:
  - Detect the rising edge of hbl with a registered previous-hbl (prev_hbl reset value 1, so no swap pulses out of reset).
  - That cycle: bank<=~bank, line_swap=1 for exactly one cycle.
  - A write already in stage 2 completes to its tagged (old write) bank, which is now the display bank. This is allowed because it lands before hbl falls.
  - Writes accepted after the swap target the new write bank.
- Simultaneous display clear and stage-2 write to the same bank/address cannot happen (the banks differ), except in the swap-boundary case above. There the stage-2 write takes precedence only if hbl=1; during hbl=1 the display port is idle.
- X wrap: wr_x is modulo 2^AW; off-screen sprite pixels simply wrap (the sprite engine clips).
- A reset asserted mid-line returns to CLEAR, and both banks are fully re-cleared.

Decomposition:
- Shared video package holds:
  - AW/DW/TW defaults.
  - The transparency test function (data[TW-1:0]==0).
  - HBL/active encoding constant (hcount[8] = active).
- One sub-module, lb_bank_ram: a single bank with one read-first clear port and one write port with registered read. It is instantiated twice; the top level holds the FSM, swap logic and write pipeline.

Test Plan:
- Reset then 256 clocks: wr_ready=0 through cycle 255, 1 at cycle 256; the first visible line outputs all 0.
- Write x=0x40 data=0x15 in line N; after the swap, on line N+1 with hcount=0x140, pix_out=0x15 one cycle later. On line N+2 the same position reads 0 (cleared).
- Write x=0x10 data=0x0B, then next cycle x=0x10 data=0x2E: display reads 0x0B (first opaque wins through the forwarding path).
- Write x=0x20 data=0x08 (low 3 bits 0, transparent) over existing 0x13: display reads 0x13.
- hbl rises while a write to x=0x7F is in stage 2: line_swap pulses once, bank toggles, and the pending pixel appears on the current display line at x=0x7F. A write accepted the next cycle appears one line later.
- Assert RESET mid-line with the buffer holding 0x21 at x=5: pix_out=0 immediately, bank=0, and after CLEAR, x=5 reads 0 in both banks.
